// File: rtl/ring_feeder.sv
// Feeds a systolic ring of N PEs: loads an NxN matrix A and vector X over a
// valid/ready stream, then seeds the PEs and streams one rotated coefficient per PE per step.

module ring_feeder_lane #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int LANE = 0,
    localparam int SW  = $clog2(N)
) (
    input  logic          clk,
    input  logic          wr_a,
    input  logic [SW-1:0] wr_col,
    input  logic          wr_x,
    input  logic [W-1:0]  wr_data,
    input  logic [SW-1:0] step,
    output logic [W-1:0]  a_sel,
    output logic [W-1:0]  x_val
);
    logic [N-1:0][W-1:0] row_q;
    logic [W-1:0]        x_q;
    logic [SW:0]         col;

    always_ff @(posedge clk) begin
        if (wr_a) row_q[wr_col] <= wr_data;
        if (wr_x) x_q <= wr_data;
    end

    // (LANE + step) mod N, both operands < N so one conditional subtract suffices
    always_comb begin
        col = (SW+1)'(LANE) + {1'b0, step};
        if (col >= (SW+1)'(N)) col = col - (SW+1)'(N);
    end

    assign a_sel = row_q[col[SW-1:0]];
    assign x_val = x_q;
endmodule

module ring_feeder #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pe_load,
    output logic         pe_en,
    output logic [N*W-1:0] x_init_bus,
    output logic [N*W-1:0] a_bus
);
    localparam int SW = $clog2(N);
    localparam int NW = N*N + N;
    localparam int CW = $clog2(NW);

    typedef enum logic [2:0] {IDLE, LOAD, LOADED, INIT, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] wcnt, wcnt_n;
    logic [SW:0]   row, row_n;     // row == N addresses the X vector
    logic [SW-1:0] col, col_n;
    logic [SW-1:0] s, s_n;
    logic          xfer, last_word;

    logic [N-1:0][W-1:0] a_sel, x_val, a_q, x_q;

    assign xfer      = in_valid && in_ready;
    assign last_word = (wcnt == CW'(NW-1));

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        row_n   = row;
        col_n   = col;
        s_n     = s;
        if (xfer && !last_word) begin
            wcnt_n = wcnt + CW'(1);
            if (col == SW'(N-1)) begin
                col_n = '0;
                row_n = row + (SW+1)'(1);
            end else begin
                col_n = col + SW'(1);
            end
        end
        case (state)
            IDLE:    if (xfer) state_n = last_word ? LOADED : LOAD;
            LOAD:    if (xfer && last_word) state_n = LOADED;
            LOADED:  if (start) state_n = INIT;
            INIT: begin
                state_n = RUN;
                s_n     = '0;
            end
            RUN: begin
                if (s == SW'(N-1)) state_n = DONE;
                else               s_n = s + SW'(1);
            end
            DONE: begin
                state_n = IDLE;
                wcnt_n  = '0;
                row_n   = '0;
                col_n   = '0;
                s_n     = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Lanes read with the next step so a_bus is registered alongside the state.
    for (genvar i = 0; i < N; i++) begin : g_lane
        ring_feeder_lane #(.N(N), .W(W), .LANE(i)) u_lane (
            .clk     (clk),
            .wr_a    (xfer && row == (SW+1)'(i)),
            .wr_col  (col),
            .wr_x    (xfer && row == (SW+1)'(N) && col == SW'(i)),
            .wr_data (in_data),
            .step    (s_n),
            .a_sel   (a_sel[i]),
            .x_val   (x_val[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wcnt     <= '0;
            row      <= '0;
            col      <= '0;
            s        <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_load  <= 1'b0;
            pe_en    <= 1'b0;
            x_q      <= '0;
            a_q      <= '0;
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            row      <= row_n;
            col      <= col_n;
            s        <= s_n;
            in_ready <= (state_n == IDLE) || (state_n == LOAD);
            busy     <= (state_n == INIT) || (state_n == RUN);
            done     <= (state_n == DONE);
            pe_load  <= (state_n == INIT);
            pe_en    <= (state_n == RUN);
            x_q      <= (state_n == INIT) ? x_val : '0;
            a_q      <= (state_n == RUN)  ? a_sel : '0;
        end
    end

    assign x_init_bus = x_q;
    assign a_bus      = a_q;
endmodule

// File: tb/tb_ring_feeder.sv
// Randomized bench for ring_feeder: a driver loads/starts runs and pushes expected
// PE-side beats into a queue; a monitor pops and compares every active output cycle.

module tb_ring_feeder;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int NW = N*N + N;
    localparam int EW = 4 + 2*N*W;

    logic clk = 1'b0, reset = 1'b0;
    logic [W-1:0] in_data = '0;
    logic in_valid = 1'b0, start = 1'b0;
    logic in_ready, busy, done, pe_load, pe_en;
    logic [N*W-1:0] x_init_bus, a_bus;

    ring_feeder #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .busy(busy), .done(done),
        .pe_load(pe_load), .pe_en(pe_en), .x_init_bus(x_init_bus), .a_bus(a_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [EW-1:0] exp;
    } item_t;

    item_t        sbq[$];
    int           tests = 0, fails = 0;
    int           cyc = 0;
    bit           mon_on = 1'b0;
    logic [W-1:0] cur[NW];
    logic [W-1:0] acc[$], prev[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any activity on PE-side outputs must match the queue front at the right cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [EW-1:0] obs;
            item_t it;
            obs = {busy, pe_load, pe_en, done, x_init_bus, a_bus};
            if (obs != '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", obs, '0);
                end else begin
                    it = sbq.pop_front();
                    chk("beat_cycle", cyc, it.cyc);
                    chk("beat_value", obs, it.exp);
                end
            end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                it = sbq.pop_front();
                chk("missed_beat", obs, it.exp);
            end
        end
    end

    // Reference: at step s PE i sees A[i][(i+s) mod N]; INIT seeds X[i].
    task automatic push_run(input int ks);
        item_t it;
        logic [N*W-1:0] bus;
        for (int i = 0; i < N; i++) bus[i*W +: W] = cur[N*N + i];
        it.cyc = ks;
        it.exp = {1'b1, 1'b1, 1'b0, 1'b0, bus, {(N*W){1'b0}}};
        sbq.push_back(it);
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < N; i++) bus[i*W +: W] = cur[i*N + (i + s) % N];
            it.cyc = ks + 1 + s;
            it.exp = {1'b1, 1'b0, 1'b1, 1'b0, {(N*W){1'b0}}, bus};
            sbq.push_back(it);
        end
        it.cyc = ks + N + 1;
        it.exp = {1'b0, 1'b0, 1'b0, 1'b1, {(2*N*W){1'b0}}};
        sbq.push_back(it);
    endtask

    task automatic load(input bit gaps, input bit start_mid);
        int idx = 0, guard = 0;
        bit v;
        acc.delete();
        while (idx < NW && guard < 2000) begin
            @(negedge clk);
            guard++;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = v ? cur[idx] : W'($urandom);
            start    = start_mid && (idx == 7);
            if (v && in_ready) begin
                acc.push_back(cur[idx]);
                idx++;
            end
        end
        start = 1'b0;
        if (guard >= 2000) chk("load_timeout", idx, NW);
        // Overflow attempt: keep offering 0xFFFF once the matrix is full.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ready_low_after_load", in_ready, 1'b0);
            in_valid = 1'b1;
            in_data  = '1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input bit extra_start);
        int ks;
        @(negedge clk);
        start = 1'b1;
        ks = cyc + 1;
        push_run(ks);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = extra_start;
        @(negedge clk);
        start = 1'b0;
        while (cyc < ks + N + 2) @(negedge clk);
        chk("ready_after_done", in_ready, 1'b1);
        chk("scoreboard_drained", sbq.size(), 0);
    endtask

    task automatic rand_words();
        for (int k = 0; k < NW; k++) cur[k] = W'($urandom_range(0, 16'h7FFF));
    endtask

    initial begin
        int ks;
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_ctrl", {busy, done, pe_load, pe_en}, 4'b0);
        chk("rst_xbus", x_init_bus, '0);
        chk("rst_abus", a_bus, '0);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", in_ready, 1'b1);
        mon_on = 1'b1;

        // start in IDLE must do nothing
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_start_ignored", in_ready, 1'b1);

        // Directed pattern A[i][j] = 16*i + j, X = 1..4
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) cur[i*N + j] = W'(16*i + j);
        for (int i = 0; i < N; i++) cur[N*N + i] = W'(i + 1);
        load(1'b0, 1'b1);
        prev = acc;
        run(1'b1);

        // Same data with handshake gaps
        load(1'b1, 1'b0);
        chk("gap_word_count", acc.size(), prev.size());
        for (int k = 0; k < NW; k++) chk("gap_word", acc[k], prev[k]);
        run(1'b0);

        for (int r = 0; r < 3; r++) begin
            rand_words();
            load(r[0], 1'b1);
            run(r[1]);
        end

        // Reset during step 2
        rand_words();
        load(1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1;
        ks = cyc + 1;
        push_run(ks);
        @(negedge clk);
        start = 1'b0;
        while (cyc < ks + 3) @(negedge clk);
        mon_on = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("abort_ctrl", {busy, done, pe_load, pe_en}, 4'b0);
        chk("abort_xbus", x_init_bus, '0);
        chk("abort_abus", a_bus, '0);
        sbq.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        chk("abort_start_ignored", in_ready, 1'b1);

        // Recovery: a full reload must again take exactly NW words
        rand_words();
        load(1'b0, 1'b0);
        run(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
